// File: rtl/uart_wb_master.sv
// uart_wb_master: UART 8N1 receiver feeding a Wishbone B4 pipelined write master.
// Five received bytes (address A, then data D3..D0 MSB first) launch one
// 32-bit write to {24'h0, A}. err_o pulses on framing errors, overruns,
// partial-frame timeouts and (optionally) ack timeouts.
// Optional feature macro: UART_WB_MASTER_ACK_TIMEOUT_EN enables the ack timeout.
module uart_wb_master #(
  parameter int TICKS_PER_BAUD = 104,
  parameter int IDLE_TIMEOUT   = 65535,
  parameter int ACK_TIMEOUT    = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        uart_rx_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  output logic        err_o
);

  localparam int TW   = $clog2(TICKS_PER_BAUD);
  localparam int HALF = TICKS_PER_BAUD / 2;
  localparam int IW   = $clog2(IDLE_TIMEOUT + 1);

  // Reject parameter values the bit timing and timers cannot support.
  if (TICKS_PER_BAUD < 4 || IDLE_TIMEOUT < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("uart_wb_master: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bus_state_t;

  rx_state_t  rx_state_reg, rx_state_next;
  bus_state_t bus_state_reg, bus_state_next;

  logic [1:0]    sync_reg;
  logic          rx_sync, rx_prev_reg;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          byte_valid, frame_err;

  logic [2:0]    cnt_reg;
  logic [7:0]    addr_reg;
  logic [23:0]   data_reg;
  logic [31:0]   adr_reg, dat_reg;
  logic [IW-1:0] idle_timer_reg;
  logic          err_reg;
  logic          byte_ok, overrun, launch, idle_expire;
  logic          ack_expire, ack_err;

  assign rx_sync = sync_reg[1];

  // Two-flop synchronizer plus edge-detect history; idles high so reset release is quiet.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], uart_rx_i};
      rx_prev_reg <= rx_sync;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_state_reg <= IDLE;
      tick_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      tick_reg     <= tick_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
    end
  end

  // Receiver next state: half-bit start check, then full-bit centre sampling.
  always_comb begin
    rx_state_next = rx_state_reg;
    tick_next     = tick_reg + 1'b1;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        tick_next = '0;
        if (rx_prev_reg && !rx_sync) rx_state_next = START;
      end
      START: begin
        if (tick_reg == TW'(HALF - 1)) begin
          tick_next     = '0;
          bit_next      = '0;
          rx_state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_reg == TW'(TICKS_PER_BAUD - 1)) begin
          tick_next  = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) rx_state_next = STOP;
        end
      end
      STOP: begin
        if (tick_reg == TW'(TICKS_PER_BAUD - 1)) begin
          tick_next     = '0;
          rx_state_next = IDLE;
          byte_valid    = rx_sync;
          frame_err     = !rx_sync;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  assign byte_ok     = byte_valid && (bus_state_reg == B_IDLE);
  assign overrun     = byte_valid && (bus_state_reg != B_IDLE);
  assign launch      = byte_ok && (cnt_reg == 3'd4);
  assign idle_expire = (cnt_reg != 3'd0) && !byte_ok &&
                       (idle_timer_reg == IW'(IDLE_TIMEOUT - 1));

  // Frame assembly, partial-frame timeout, write latching and the merged error pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_reg        <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      idle_timer_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= frame_err | overrun | idle_expire | ack_err;
      if (byte_ok) begin
        idle_timer_reg <= '0;
        if (launch) begin
          cnt_reg <= '0;
          adr_reg <= {24'h0, addr_reg};
          dat_reg <= {data_reg, shift_reg};
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == 3'd0) addr_reg <= shift_reg;
          else                 data_reg <= {data_reg[15:0], shift_reg};
        end
      end else if (idle_expire) begin
        cnt_reg        <= '0;
        idle_timer_reg <= '0;
      end else if (cnt_reg != 3'd0) begin
        idle_timer_reg <= idle_timer_reg + 1'b1;
      end else begin
        idle_timer_reg <= '0;
      end
    end
  end

`ifdef UART_WB_MASTER_ACK_TIMEOUT_EN
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  logic [AW-1:0] ack_timer_reg;

  // Counts cycles of the current bus cycle; cleared whenever the bus is idle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || bus_state_reg == B_IDLE) ack_timer_reg <= '0;
    else                                     ack_timer_reg <= ack_timer_reg + 1'b1;
  end

  assign ack_expire = (bus_state_reg != B_IDLE) && (ack_timer_reg == AW'(ACK_TIMEOUT - 1));
`else
  assign ack_expire = 1'b0;
`endif

  // Bus state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) bus_state_reg <= B_IDLE;
    else          bus_state_reg <= bus_state_next;
  end

  // Bus next state: one stb accept per frame, then wait for ack; an ack wins over a timeout.
  always_comb begin
    bus_state_next = bus_state_reg;
    ack_err        = 1'b0;
    case (bus_state_reg)
      B_IDLE: if (launch) bus_state_next = B_REQ;
      B_REQ:  if (!wb_stall_i) bus_state_next = wb_ack_i ? B_IDLE : B_WAIT;
      B_WAIT: if (wb_ack_i) bus_state_next = B_IDLE;
      default: bus_state_next = B_IDLE;
    endcase
    if (ack_expire && bus_state_next != B_IDLE) begin
      bus_state_next = B_IDLE;
      ack_err        = 1'b1;
    end
  end

  assign wb_cyc_o = (bus_state_reg != B_IDLE);
  assign wb_stb_o = (bus_state_reg == B_REQ);
  assign wb_we_o  = (bus_state_reg != B_IDLE);
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign err_o    = err_reg;

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed bench for uart_wb_master (TICKS_PER_BAUD=4,
// IDLE_TIMEOUT=100, ACK_TIMEOUT=20) with a small Wishbone slave responder
// and a bus monitor; checks are immediate assertions in one linear sequence.
`timescale 1ns/1ps
module tb_uart_wb_master;
  localparam int TPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic        cyc, stb, we, err;
  logic [31:0] adr, dat;

  int total = 0;
  int bad = 0;

  // responder controls
  int stall_n = 0;
  int stb_seen = 0;
  bit ack_en = 1'b1;
  bit ack_force = 1'b0;

  // monitor results
  int          accepts = 0;
  int          stb_cycles = 0;
  int          cyc_cycles = 0;
  int          err_count = 0;
  logic [31:0] acc_adr = '0;
  logic [31:0] acc_dat = '0;
  logic        acc_we = 1'b0;

  always #5 clk = ~clk;

  uart_wb_master #(
    .TICKS_PER_BAUD(4),
    .IDLE_TIMEOUT(100),
    .ACK_TIMEOUT(20)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .uart_rx_i (rx),
    .wb_cyc_o  (cyc),
    .wb_stb_o  (stb),
    .wb_we_o   (we),
    .wb_adr_o  (adr),
    .wb_dat_o  (dat),
    .wb_stall_i(stall),
    .wb_ack_i  (ack),
    .err_o     (err)
  );

  // Slave responder: stall the first stall_n stb cycles, ack in the cycle after accept.
  initial forever begin
    @(posedge clk);
    #1;
    if (cyc && stb) begin
      stall = (stb_seen < stall_n);
      stb_seen++;
    end else begin
      stall = 1'b0;
      stb_seen = 0;
    end
    ack = ack_force || (ack_en && cyc && !stb);
  end

  // Bus monitor sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (cyc) cyc_cycles++;
    if (stb) stb_cycles++;
    if (err) err_count++;
    if (cyc && stb && !stall) begin
      accepts++;
      acc_adr = adr;
      acc_dat = dat;
      acc_we  = we;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    accepts = 0;
    stb_cycles = 0;
    cyc_cycles = 0;
    err_count = 0;
    acc_adr = '0;
    acc_dat = '0;
    acc_we = 1'b0;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    hold(1'b0, TPB);
    for (int i = 0; i < 8; i++) hold(b[i], TPB);
    hold(stop, TPB);
    hold(1'b1, 2 * TPB);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dv;
    dv = d;
    send_byte(a, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(dv[31 - 8 * i -: 8], 1'b1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cyc", {31'b0, cyc}, 32'd0);
    check("rst_stb", {31'b0, stb}, 32'd0);
    check("rst_we",  {31'b0, we},  32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat, 32'd0);

    // ack while idle is ignored
    @(posedge clk);
    #1;
    clear_mon();
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack_cyc",  cyc_cycles, 32'd0);
    check("idle_ack_err",  err_count,  32'd0);

    // basic write, no stall
    clear_mon();
    stall_n = 0;
    send_frame(8'h02, 32'h0000001F);
    repeat (4) @(posedge clk);
    #1;
    check("w1_accepts", accepts, 32'd1);
    check("w1_adr", acc_adr, 32'h00000002);
    check("w1_dat", acc_dat, 32'h0000001F);
    check("w1_we", {31'b0, acc_we}, 32'd1);
    check("w1_stb_cycles", stb_cycles, 32'd1);
    check("w1_cyc_cycles", cyc_cycles, 32'd2);
    check("w1_err", err_count, 32'd0);
    check("w1_cyc_after", {31'b0, cyc}, 32'd0);
    check("w1_we_after", {31'b0, we}, 32'd0);

    // stall held for 3 cycles
    clear_mon();
    stall_n = 3;
    send_frame(8'h02, 32'h0000001F);
    repeat (4) @(posedge clk);
    #1;
    check("w2_accepts", accepts, 32'd1);
    check("w2_stb_cycles", stb_cycles, 32'd4);
    check("w2_cyc_cycles", cyc_cycles, 32'd5);
    check("w2_dat", acc_dat, 32'h0000001F);
    stall_n = 0;

    // framing error byte is discarded, next frame is intact
    clear_mon();
    send_byte(8'h55, 1'b0);
    check("fe_err", err_count, 32'd1);
    send_frame(8'h10, 32'h12345678);
    repeat (4) @(posedge clk);
    #1;
    check("fe_accepts", accepts, 32'd1);
    check("fe_adr", acc_adr, 32'h00000010);
    check("fe_dat", acc_dat, 32'h12345678);
    check("fe_err_total", err_count, 32'd1);

    // partial frame timeout
    clear_mon();
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (150) @(posedge clk);
    #1;
    check("to_err", err_count, 32'd1);
    check("to_accepts", accepts, 32'd0);
    send_frame(8'h01, 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1;
    check("to_adr", acc_adr, 32'h00000001);
    check("to_dat", acc_dat, 32'hDEADBEEF);
    check("to_err_total", err_count, 32'd1);

    // ack withheld: overrun, or ack timeout when enabled
    clear_mon();
    ack_en = 1'b0;
    send_frame(8'h7E, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    #1;
    check("hold_cyc", {31'b0, cyc}, 32'd1);
    check("hold_stb", {31'b0, stb}, 32'd0);
    check("hold_accepts", accepts, 32'd1);
`ifdef UART_WB_MASTER_ACK_TIMEOUT_EN
    repeat (20) @(posedge clk);
    #1;
    check("ato_cyc", {31'b0, cyc}, 32'd0);
    check("ato_cyc_cycles", cyc_cycles, 32'd20);
    check("ato_err", err_count, 32'd1);
    send_frame(8'h7E, 32'hCAFEF00D);
    check("ato_rewait_cyc", {31'b0, cyc}, 32'd1);
`else
    send_byte(8'hAA, 1'b1);
    check("ovr_err", err_count, 32'd1);
    check("ovr_cyc", {31'b0, cyc}, 32'd1);
    check("ovr_adr", adr, 32'h0000007E);
    check("ovr_dat", dat, 32'hCAFEF00D);
`endif

    // reset during B_WAIT abandons the cycle
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rw_cyc", {31'b0, cyc}, 32'd0);
    check("rw_stb", {31'b0, stb}, 32'd0);
    check("rw_err", {31'b0, err}, 32'd0);
    ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    send_frame(8'h05, 32'h01020304);
    repeat (4) @(posedge clk);
    #1;
    check("rw_accepts", accepts, 32'd1);
    check("rw_adr", acc_adr, 32'h00000005);
    check("rw_dat", acc_dat, 32'h01020304);
    check("rw_err_total", err_count, 32'd0);
    check("rw_cyc_after", {31'b0, cyc}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 SHALL have parameter TICKS_PER_BAUD, default 104, clock cycles per UART bit; legal values are 4 or more.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 65535, the inter-byte gap in clock cycles that discards a partial frame.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1023, clock cycles to wait for ack; used only under REQ-030.
REQ-004 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-005 SHALL have port uart_rx_i  in  1  asynchronous UART receive line, idle high.
REQ-006 SHALL have the Wishbone B4 pipelined master ports: wb_cyc_o out 1, wb_stb_o out 1, wb_we_o out 1, wb_adr_o out 32, wb_dat_o out 32, wb_stall_i in 1, wb_ack_i in 1.
REQ-007 SHALL have port err_o  out  1  one-cycle error pulse.

Function
REQ-008 SHALL pass uart_rx_i through a 2-flop synchronizer before any other use.
REQ-009 UART RX SHALL use 8N1 framing, LSB first, with states IDLE, START, DATA, STOP.
REQ-010 IDLE->START on a synchronized falling edge; START SHALL re-sample at TICKS_PER_BAUD/2 (integer division); a high sample returns to IDLE with no error.
REQ-011 DATA SHALL sample 8 bits at full-bit intervals from the start-bit centre; STOP SHALL sample one bit later.
REQ-012 Stop bit = 1 delivers the byte to the frame assembler; stop bit = 0 discards the byte and pulses err_o (framing error).
REQ-013 A frame SHALL be 5 bytes: address byte A, then data bytes D3, D2, D1, D0 (MSB first).
REQ-014 A byte counter (0..4) SHALL count accepted bytes; the 5th byte SHALL launch the bus write and clear the counter.
REQ-015 SHALL set wb_adr_o = {24'h0, A}, wb_dat_o = {D3, D2, D1, D0}, wb_we_o = 1 at launch.
REQ-016 Bus FSM states SHALL be B_IDLE, B_REQ, B_WAIT.
REQ-017 On launch, the cycle after the 5th byte is accepted, the FSM SHALL enter B_REQ with wb_cyc_o = wb_stb_o = 1.
REQ-018 In B_REQ, wb_stb_o SHALL stay high while wb_stall_i = 1; on a clock edge with wb_stall_i = 0 the FSM SHALL go to B_WAIT and drop wb_stb_o.
REQ-019 wb_cyc_o SHALL stay high through B_WAIT until the clock edge where wb_ack_i = 1, then return to B_IDLE with wb_cyc_o = 0 and wb_we_o = 0.
REQ-020 An ack arriving in B_REQ on the same edge as wb_stall_i = 0 SHALL complete the cycle directly to B_IDLE.
REQ-021 wb_ack_i SHALL be ignored in B_IDLE.
REQ-022 Exactly one stb-accept SHALL occur per frame; wb_adr_o and wb_dat_o SHALL be stable from launch until cyc drops.
REQ-023 A byte completing while the bus FSM is not in B_IDLE SHALL be dropped, pulse err_o (overrun), and leave the counter unchanged.
REQ-024 With the counter nonzero, a gap of IDLE_TIMEOUT cycles with no accepted byte SHALL reset the counter to 0 and pulse err_o.
REQ-025 Events coinciding with an err_o pulse SHALL still produce a single one-cycle err_o pulse.

Reset
REQ-026 Reset SHALL set wb_cyc_o, wb_stb_o, wb_we_o and err_o to 0, and wb_adr_o and wb_dat_o to 0.
REQ-027 Reset SHALL return the RX FSM to IDLE, the bus FSM to B_IDLE, and the byte counter and all timers to 0.
REQ-028 Reset asserted during a bus cycle SHALL abandon it; cyc and stb SHALL be low the cycle after the reset edge.
REQ-029 The synchronizer SHALL reset to 1 so that reset release does not produce a false start.

Configuration
REQ-030 With macro UART_WB_MASTER_ACK_TIMEOUT_EN defined, the module SHALL count cycles spent in B_REQ/B_WAIT; reaching ACK_TIMEOUT SHALL drop cyc and stb, return to B_IDLE, and pulse err_o.
REQ-031 Without UART_WB_MASTER_ACK_TIMEOUT_EN, the module SHALL wait for ack indefinitely and SHALL contain no ack-timeout logic.

Verification (TICKS_PER_BAUD=4, IDLE_TIMEOUT=100, ACK_TIMEOUT=20)
REQ-032 Send bytes 0x02 0x00 0x00 0x00 0x1F with stall=0 and ack one cycle after stb -> exactly one write with adr=0x00000002 and dat=0x0000001F, stb high for 1 cycle, err_o never high.
REQ-033 Same frame with stall held high 3 cycles -> stb high 4 cycles, one accept, cyc drops on the ack edge.
REQ-034 Send byte 0x55 with stop bit 0, then a valid 5-byte frame -> one err_o pulse, then a correct write; the bad byte is not counted.
REQ-035 Send 2 bytes, idle 150 cycles, then 0x01 0xDE 0xAD 0xBE 0xEF -> one err_o pulse, then a write with adr=0x1 and dat=0xDEADBEEF.
REQ-036 With ack withheld, send a 6th byte during B_WAIT -> err_o pulse (overrun); with the macro defined, cyc drops 20 cycles after launch with an err_o pulse; with it undefined, cyc stays high.
REQ-037 Assert wb_rst_i for 1 cycle during B_WAIT -> cyc, stb and err_o are 0 the following cycle, and a subsequent frame writes correctly.
